// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv
//  Description : HI/LO register pair with an iterative shift-add multiplier
//                and restoring divider (MULT/MULTU/DIV/DIVU, W+1 cycles),
//                plus single-cycle MTHI/MTLO writes.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi_q,
    output logic [W-1:0] lo_q
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  c_last   = CW'(W - 1);
    localparam logic [2:0]     c_op_mthi = 3'd4;
    localparam logic [2:0]     c_op_mtlo = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_ma;        // |a|; shifts left (dividend bits) when dividing
    logic [W-1:0]    r_mb;        // |b|; shifts right (multiplier bits) when multiplying
    logic [2*W-1:0]  r_acc;       // product, or {remainder, quotient}
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_q;     // result / quotient must be negated
    logic            r_neg_r;     // remainder takes the dividend sign
    logic            r_bzero;
    logic            r_done;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_idle;
    logic            w_accept;
    logic            w_mthi;
    logic            w_mtlo;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [W-1:0]    w_mag_a;
    logic [W-1:0]    w_mag_b;
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_nxt;
    logic [W:0]      w_div_shift;
    logic [W:0]      w_div_diff;
    logic            w_div_qbit;
    logic [W-1:0]    w_div_rem;
    logic [2*W-1:0]  w_div_nxt;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_res_hi;
    logic [W-1:0]    w_res_lo;

    assign w_idle   = (r_state == S_IDLE);
    // MTHI/MTLO and mul/div requests are all blocked while busy or flushing
    assign w_accept = start & ~cancel & w_idle & ~op[2];
    assign w_mthi   = start & ~cancel & w_idle & (op == c_op_mthi);
    assign w_mtlo   = start & ~cancel & w_idle & (op == c_op_mtlo);

    // Signed ops are the even opcodes (MULT=0, DIV=2)
    assign w_sign_a = ~op[0] & a[W-1];
    assign w_sign_b = ~op[0] & b[W-1];
    assign w_mag_a  = w_sign_a ? -a : a;
    assign w_mag_b  = w_sign_b ? -b : b;

    // Shift-add step: add |a| into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_mb[0] ? {1'b0, r_ma} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};

    // Restoring step: bring in the next dividend bit, trial-subtract |b|,
    // keep the difference only when it did not borrow.
    assign w_div_shift = {r_acc[2*W-1:W], r_ma[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mb};
    assign w_div_qbit  = ~w_div_diff[W];
    assign w_div_rem   = w_div_qbit ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
    assign w_div_nxt   = {w_div_rem, r_acc[W-2:0], w_div_qbit};

    // Sign fix-up applied on the write edge. With b=0 the remainder path
    // naturally ends holding |a|, so HI comes back as the original a.
    assign w_prod = r_neg_q ? -r_acc : r_acc;

    // Select the final HI/LO values for the operation in flight
    always_comb begin
        w_res_hi = w_prod[2*W-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_is_div) begin
            w_res_hi = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
            if (r_bzero) begin
                w_res_lo = '1;
            end else begin
                w_res_lo = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a flush always returns the engine to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (cancel) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: operand latch, iteration, HI/LO writes and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == S_FIN) & ~cancel;

            if (w_accept) begin
                r_ma     <= w_mag_a;
                r_mb     <= w_mag_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_sign_a ^ w_sign_b;
                r_neg_r  <= w_sign_a;
                r_bzero  <= (b == '0);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_is_div) begin
                    r_acc <= w_div_nxt;
                    r_ma  <= {r_ma[W-2:0], 1'b0};
                end else begin
                    r_acc <= w_mul_nxt;
                    r_mb  <= {1'b0, r_mb[W-1:1]};
                end
            end

            if ((r_state == S_FIN) && !cancel) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_mthi) begin
                r_hi <= a;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end
        end
    end

    assign busy = ~w_idle;
    assign done = r_done;
    assign hi_q = r_hi;
    assign lo_q = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv
//  Description : Self-checking bench for hilo_muldiv (W=32): directed vectors
//                with hand-computed results, control corner cases and a short
//                run of random mul/div against an arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    int n_checks = 0;
    int n_errors = 0;

    hilo_muldiv #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi_q   (hi_q),
        .lo_q   (lo_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; operands are scrambled afterwards since the engine
    // must have latched them at the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int c;
        issue(o, x, y);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_idle(c);
        check({tag, " latency"}, 64'(c), 64'd33);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi_q), 64'(eh));
        check({tag, " lo"}, 64'(lo_q), 64'(el));
        tick();
        check({tag, " done end"}, 64'(done), 64'd0);
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        int          ix;
        int          iy;
        longint      ps;
        logic [63:0] pu;
        logic [31:0] q;
        logic [31:0] r;
        ix = x;
        iy = y;
        case (o)
            3'd0: begin
                ps = longint'(ix) * longint'(iy);
                return 64'(ps);
            end
            3'd1: begin
                pu = {32'd0, x} * {32'd0, y};
                return pu;
            end
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ix / iy;
                r = ix % iy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    initial begin
        int          c;
        int          done_seen;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset hi", 64'(hi_q), 64'd0);
        check("reset lo", 64'(lo_q), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        // Single-cycle moves
        issue(3'd4, 32'h0000_ABCD, 32'd0);
        check("mthi hi", 64'(hi_q), 64'h0000_ABCD);
        check("mthi lo", 64'(lo_q), 64'd0);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        issue(3'd5, 32'h5555_AAAA, 32'd0);
        check("mtlo lo", 64'(lo_q), 64'h5555_AAAA);

        // No-op opcode and requests blocked by a flush
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        check("op6 busy", 64'(busy), 64'd0);
        check("op6 hilo", {hi_q, lo_q}, {32'h0000_ABCD, 32'h5555_AAAA});
        cancel = 1'b1;
        issue(3'd1, 32'd3, 32'd4);
        check("cancel+start busy", 64'(busy), 64'd0);
        issue(3'd4, 32'hFFFF_0000, 32'd0);
        cancel = 1'b0;
        check("cancel+mthi hi", 64'(hi_q), 64'h0000_ABCD);
        tick();
        check("cancel+start done", 64'(done), 64'd0);

        // Directed arithmetic vectors
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo);
        end

        // MTLO while busy is dropped
        issue(3'd1, 32'd3, 32'd4);
        tick();
        tick();
        start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("mtlo busy lo", 64'(lo_q), 64'hFFFF_FFFF);
        wait_idle(c);
        check("mtlo busy result", {hi_q, lo_q}, 64'd12);

        // Back-to-back: second start in the done cycle
        tick();
        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(c);
        check("b2b done1", 64'(done), 64'd1);
        check("b2b result1", {hi_q, lo_q}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(3'd3, 32'h0000_03E8, 32'h0000_0003);
        check("b2b busy2", 64'(busy), 64'd1);
        check("b2b done drop", 64'(done), 64'd0);
        wait_idle(c);
        check("b2b latency2", 64'(c), 64'd33);
        check("b2b result2", {hi_q, lo_q}, {32'd1, 32'd333});

        // Cancel at iteration 10
        tick();
        issue(3'd4, 32'h1111_2222, 32'd0);
        issue(3'd5, 32'h3333_4444, 32'd0);
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel hilo", {hi_q, lo_q}, 64'h1111_2222_3333_4444);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done) done_seen = 1;
        end
        check("cancel no done", 64'(done_seen), 64'd0);

        // Cancel in FIN suppresses the write
        issue(3'd0, 32'd2, 32'd3);
        repeat (32) tick();
        check("fin busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("fin cancel busy", 64'(busy), 64'd0);
        check("fin cancel done", 64'(done), 64'd0);
        check("fin cancel hilo", {hi_q, lo_q}, 64'h1111_2222_3333_4444);
        tick();
        check("fin cancel done2", 64'(done), 64'd0);

        // Random mul/div against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = {{16{rb[15]}}, rb[15:0]};
            exp = model(ro, ra, rb);
            run_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb,
                   exp[63:32], exp[31:0]);
        end

        // Reset in the middle of a divide
        issue(3'd3, 32'h0000_1000, 32'h0000_0003);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst hilo", {hi_q, lo_q}, 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        run_op("after rst", 3'd3, 32'h0000_1000, 32'h0000_0003, 32'd1, 32'h0000_0555);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
